bomb_timer: RTL and testbench

Downstream of the player controller: accepts the registered single-cycle bomb-placement pulses and tile coordinates, holds each live bomb in a per-player slot with a fuse counter, and reports live-bomb counts back to the controller's `bomb_num` inputs. When a fuse expires, it emits one explosion event per cycle (coordinate plus owner) to the flame/grid stage.

---
 rtl/bomb_pkg.sv | 32 +++
 rtl/bomb_timer_if.sv | 42 ++++
 rtl/bomb_slot.sv | 82 ++++++++
 rtl/bomb_timer.sv | 191 +++++++++++++++++++
 tb/tb_bomb_timer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_pkg.sv
// -----------------------------------------------------------------------------
// bomb_pkg
// Shared types and constants for the bomb timer and the flame stage.
//   slot_state_e : per-slot lifecycle (IDLE -> ARMED -> PENDING -> IDLE)
//   owner_e      : owning player of a bomb / explosion event
//   tile_t       : tile index, y*16+x
//   DEFAULT_*    : fuse timing defaults shared with the flame stage
// -----------------------------------------------------------------------------
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } slot_state_e;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } owner_e;

    typedef logic [7:0] tile_t;

    localparam int DEFAULT_FUSE_TICKS = 3;
    localparam int DEFAULT_TICK_DIV   = 10_000_000;

    // Bits needed to hold a fuse value 0..ticks; never narrower than 1 bit.
    function automatic int fuse_width(input int ticks);
        return (ticks < 1) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/bomb_timer_if.sv
// -----------------------------------------------------------------------------
// bomb_timer_if
// Bundles the placement requests, flame-hit feedback, live-bomb counts and the
// explosion event stream between the player controller / flame stage (master)
// and the bomb timer (slave).
//   p1/p2_set_bomb, p1/p2_coordinate : single-cycle placement request + tile
//   detonate_valid, detonate_coord   : flame hit (used by chain detonation)
//   bomb_num_1, bomb_num_2           : live bombs per player
//   place_reject                     : bit0/bit1 pulse on dropped P1/P2 request
//   explode_valid/coord/owner        : one explosion event per cycle
// -----------------------------------------------------------------------------
interface bomb_timer_if;
    import bomb_pkg::*;

    logic       p1_set_bomb;
    logic       p2_set_bomb;
    tile_t      p1_coordinate;
    tile_t      p2_coordinate;
    logic       detonate_valid;
    tile_t      detonate_coord;
    logic [2:0] bomb_num_1;
    logic [2:0] bomb_num_2;
    logic [1:0] place_reject;
    logic       explode_valid;
    tile_t      explode_coord;
    owner_e     explode_owner;

    modport master (
        output p1_set_bomb, p2_set_bomb, p1_coordinate, p2_coordinate,
        output detonate_valid, detonate_coord,
        input  bomb_num_1, bomb_num_2, place_reject,
        input  explode_valid, explode_coord, explode_owner
    );

    modport slave (
        input  p1_set_bomb, p2_set_bomb, p1_coordinate, p2_coordinate,
        input  detonate_valid, detonate_coord,
        output bomb_num_1, bomb_num_2, place_reject,
        output explode_valid, explode_coord, explode_owner
    );

endinterface

// File: rtl/bomb_slot.sv
// -----------------------------------------------------------------------------
// bomb_slot
// One bomb slot: state, tile and fuse counter.
//   clk, rst    : clock, asynchronous active-low reset
//   load        : arm this slot with load_coord (only honoured while IDLE)
//   load_coord  : tile of the new bomb
//   tick        : prescaler tick, decrements the fuse of an ARMED slot
//   clear       : emission grant, returns a PENDING slot to IDLE
//   det_match   : flame hit on this slot's tile, forces ARMED -> PENDING
//   state, coord: current slot state and tile
// -----------------------------------------------------------------------------
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_TICKS = DEFAULT_FUSE_TICKS,
    parameter int FUSE_W     = fuse_width(DEFAULT_FUSE_TICKS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  tile_t       load_coord,
    input  logic        tick,
    input  logic        clear,
    input  logic        det_match,
    output slot_state_e state,
    output tile_t       coord
);

    slot_state_e       state_q, state_d;
    tile_t             coord_q, coord_d;
    logic [FUSE_W-1:0] fuse_q,  fuse_d;

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of its neighbours regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            coord_q <= '0;
            fuse_q  <= '0;
        end else begin
            state_q <= state_d;
            coord_q <= coord_d;
            fuse_q  <= fuse_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no branch
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        coord_d = coord_q;
        fuse_d  = fuse_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = ARMED;
                    coord_d = load_coord;
                    fuse_d  = FUSE_W'(FUSE_TICKS);
                end
            end
            ARMED: begin
                // A flame hit and a final tick in the same cycle collapse into
                // a single PENDING transition.
                if (det_match || (tick && fuse_q == FUSE_W'(1))) begin
                    state_d = PENDING;
                end else if (tick) begin
                    fuse_d = fuse_q - 1'b1;
                end
            end
            PENDING: begin
                if (clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;
    assign coord = coord_q;

endmodule

// File: rtl/bomb_timer.sv
// -----------------------------------------------------------------------------
// bomb_timer
// Holds each live bomb in a per-player slot with a fuse, reports live-bomb
// counts and emits one explosion event per cycle when fuses expire.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : bomb_timer_if.slave (placement, flame hit, counts, explosions)
// Parameters: SLOTS_PER_PLAYER (1..7), TICK_DIV (clk cycles per fuse tick),
//             FUSE_TICKS (ticks from arming to expiry).
// Optional feature: define BOMB_TIMER_CHAIN_DETONATE_EN to let a flame hit
// (detonate_valid/detonate_coord) send a matching ARMED bomb straight to
// PENDING. Without it the detonate inputs are ignored.
// -----------------------------------------------------------------------------
module bomb_timer
    import bomb_pkg::*;
#(
    parameter int SLOTS_PER_PLAYER = 5,
    parameter int TICK_DIV         = DEFAULT_TICK_DIV,
    parameter int FUSE_TICKS       = DEFAULT_FUSE_TICKS
) (
    input logic         clk,
    input logic         rst,
    bomb_timer_if.slave bus
);

    localparam int N      = SLOTS_PER_PLAYER;
    localparam int NS     = 2 * N;               // P1 slots 0..N-1, P2 slots N..2N-1
    localparam int FUSE_W = fuse_width(FUSE_TICKS);
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // ---------------- prescaler ----------------
    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- slots ----------------
    slot_state_e   slot_state [NS];
    tile_t         slot_coord [NS];
    logic [NS-1:0] busy;
    logic [NS-1:0] pending;
    logic [NS-1:0] load;
    logic [NS-1:0] grant;
    logic [NS-1:0] det_match;

    for (genvar i = 0; i < NS; i++) begin : g_slot
        bomb_slot #(
            .FUSE_TICKS (FUSE_TICKS),
            .FUSE_W     (FUSE_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[i]),
            .load_coord ((i < N) ? bus.p1_coordinate : bus.p2_coordinate),
            .tick       (tick),
            .clear      (grant[i]),
            .det_match  (det_match[i]),
            .state      (slot_state[i]),
            .coord      (slot_coord[i])
        );
    end

    always_comb begin
        busy    = '0;
        pending = '0;
        for (int i = 0; i < NS; i++) begin
            busy[i]    = (slot_state[i] != IDLE);
            pending[i] = (slot_state[i] == PENDING);
        end
    end

`ifdef BOMB_TIMER_CHAIN_DETONATE_EN
    always_comb begin
        det_match = '0;
        for (int i = 0; i < NS; i++) begin
            det_match[i] = bus.detonate_valid && (slot_state[i] == ARMED)
                           && (slot_coord[i] == bus.detonate_coord);
        end
    end
`else
    logic unused_detonate;
    assign det_match       = '0;
    assign unused_detonate = ^{bus.detonate_valid, bus.detonate_coord};
`endif

    // ---------------- placement: duplicate + free-slot search ----------------
    logic         p1_dup, p2_dup;
    logic         p1_has_free, p2_has_free;
    logic [N-1:0] p1_sel, p2_sel;
    logic         p1_accept, p2_accept;
    logic [1:0]   reject_d, reject_q;

    always_comb begin
        p1_dup      = 1'b0;
        p2_dup      = 1'b0;
        p1_has_free = 1'b0;
        p2_has_free = 1'b0;
        p1_sel      = '0;
        p2_sel      = '0;
        // Any live bomb of either player blocks its tile, including one that
        // is being emitted this very cycle.
        for (int i = 0; i < NS; i++) begin
            if (busy[i] && slot_coord[i] == bus.p1_coordinate) p1_dup = 1'b1;
            if (busy[i] && slot_coord[i] == bus.p2_coordinate) p2_dup = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (!busy[i] && !p1_has_free) begin
                p1_has_free = 1'b1;
                p1_sel[i]   = 1'b1;
            end
            if (!busy[N+i] && !p2_has_free) begin
                p2_has_free = 1'b1;
                p2_sel[i]   = 1'b1;
            end
        end
        p1_accept = bus.p1_set_bomb && !p1_dup && p1_has_free;
        // Same-tile race in one cycle: P1 wins.
        p2_accept = bus.p2_set_bomb && !p2_dup && p2_has_free
                    && !(p1_accept && bus.p1_coordinate == bus.p2_coordinate);
        load      = {({N{p2_accept}} & p2_sel), ({N{p1_accept}} & p1_sel)};
        reject_d  = {bus.p2_set_bomb && !p2_accept, bus.p1_set_bomb && !p1_accept};
    end

    // ---------------- emission arbiter: fixed priority ----------------
    logic   grant_found;
    tile_t  grant_coord;
    owner_e grant_owner;

    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        grant_coord = '0;
        grant_owner = P1;
        for (int i = 0; i < NS; i++) begin
            if (pending[i] && !grant_found) begin
                grant_found = 1'b1;
                grant[i]    = 1'b1;
                grant_coord = slot_coord[i];
                grant_owner = (i < N) ? P1 : P2;
            end
        end
    end

    // ---------------- live-bomb popcount ----------------
    logic [2:0] cnt_1, cnt_2;

    always_comb begin
        cnt_1 = '0;
        cnt_2 = '0;
        for (int i = 0; i < N; i++) begin
            cnt_1 = cnt_1 + {2'b00, busy[i]};
            cnt_2 = cnt_2 + {2'b00, busy[N+i]};
        end
    end

    // ---------------- registered outputs ----------------
    // The reject decision is staged once more so it lines up with bomb_num,
    // which reflects the slot state one edge after the request is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reject_q          <= '0;
            bus.place_reject  <= '0;
            bus.bomb_num_1    <= '0;
            bus.bomb_num_2    <= '0;
            bus.explode_valid <= 1'b0;
            bus.explode_coord <= '0;
            bus.explode_owner <= P1;
        end else begin
            reject_q          <= reject_d;
            bus.place_reject  <= reject_q;
            bus.bomb_num_1    <= cnt_1;
            bus.bomb_num_2    <= cnt_2;
            bus.explode_valid <= grant_found;
            if (grant_found) begin
                bus.explode_coord <= grant_coord;
                bus.explode_owner <= grant_owner;
            end
        end
    end

endmodule

// File: tb/tb_bomb_timer.sv
// -----------------------------------------------------------------------------
// tb_bomb_timer
// Self-checking bench for bomb_timer with TICK_DIV=4, FUSE_TICKS=3,
// SLOTS_PER_PLAYER=5. Placement/count/reject behaviour is table driven;
// every accepted bomb pushes its expected explosion onto a scoreboard queue
// that a monitor pops when explode_valid is seen.
// -----------------------------------------------------------------------------
module tb_bomb_timer;
    import bomb_pkg::*;

    localparam int N  = 5;
    localparam int TD = 4;
    localparam int FT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bomb_timer_if bus ();

    bomb_timer #(
        .SLOTS_PER_PLAYER (N),
        .TICK_DIV         (TD),
        .FUSE_TICKS       (FT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_explode = 0;

    typedef struct packed {
        tile_t coord;
        logic  owner;
    } ev_t;

    ev_t exp_q[$];

    typedef struct {
        logic       p1_set;
        tile_t      p1_coord;
        logic       p2_set;
        tile_t      p2_coord;
        logic [1:0] rej;
        logic [2:0] num1;
        logic [2:0] num2;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s1, input tile_t c1, input logic s2, input tile_t c2);
        bus.p1_set_bomb   = s1;
        bus.p1_coordinate = c1;
        bus.p2_set_bomb   = s2;
        bus.p2_coordinate = c2;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || bus.bomb_num_1 != 0 || bus.bomb_num_2 != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_num1_zero"}, bus.bomb_num_1, 0);
        check({name, "_num2_zero"}, bus.bomb_num_2, 0);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every explosion must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus.explode_valid) begin
            n_explode++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_explode: got coord 0x%0h owner %0d, expected no event",
                         bus.explode_coord, bus.explode_owner);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("sb_explode_coord", bus.explode_coord, e.coord);
                check("sb_explode_owner", bus.explode_owner, e.owner);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int t_req;
        int lat;
        int snap;

        rst = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        bus.detonate_valid = 1'b0;
        bus.detonate_coord = '0;

        // ---------------- reset values ----------------
        #12;
        check("rst_bomb_num_1", bus.bomb_num_1, 0);
        check("rst_bomb_num_2", bus.bomb_num_2, 0);
        check("rst_place_reject", bus.place_reject, 0);
        check("rst_explode_valid", bus.explode_valid, 0);
        check("rst_explode_coord", bus.explode_coord, 0);
        check("rst_explode_owner", bus.explode_owner, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- single bomb ----------------
        drive(1'b1, 8'h23, 1'b0, '0);
        exp_q.push_back('{coord: 8'h23, owner: 1'b0});
        t_req = cyc + 1;
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0);
        @(negedge clk);
        check("single_num1_one", bus.bomb_num_1, 1);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.explode_valid) found = 1'b1;
        end
        check("single_explode_seen", found, 1);
        lat = cyc - t_req;
        // 9..12 cycles arming-to-PENDING, plus the registered emission edge.
        check("single_latency_in_10_13", (lat >= 10 && lat <= 13), 1);
        @(negedge clk);
        check("single_no_repeat", bus.explode_valid, 0);
        check("single_num1_back_zero", bus.bomb_num_1, 0);
        drain("single");

        // ---------------- table: collision + capacity ----------------
        vecs[0] = '{1'b1, 8'h40, 1'b1, 8'h40, 2'b10, 3'd1, 3'd0};  // same tile, P1 wins
        vecs[1] = '{1'b1, 8'h41, 1'b1, 8'h40, 2'b10, 3'd2, 3'd0};  // P2 hits live P1 bomb
        vecs[2] = '{1'b1, 8'h42, 1'b0, 8'h00, 2'b00, 3'd3, 3'd0};
        vecs[3] = '{1'b1, 8'h43, 1'b0, 8'h00, 2'b00, 3'd4, 3'd0};
        vecs[4] = '{1'b1, 8'h44, 1'b1, 8'h50, 2'b00, 3'd5, 3'd1};  // P1 now full
        vecs[5] = '{1'b1, 8'h45, 1'b0, 8'h00, 2'b01, 3'd5, 3'd1};  // 6th P1 rejected
        vecs[6] = '{1'b1, 8'h46, 1'b1, 8'h51, 2'b01, 3'd5, 3'd2};
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                check($sformatf("vec%0d_place_reject", j - 2), bus.place_reject, vecs[j-2].rej);
                check($sformatf("vec%0d_bomb_num_1", j - 2), bus.bomb_num_1, vecs[j-2].num1);
                check($sformatf("vec%0d_bomb_num_2", j - 2), bus.bomb_num_2, vecs[j-2].num2);
            end
            if (j < 7) begin
                drive(vecs[j].p1_set, vecs[j].p1_coord, vecs[j].p2_set, vecs[j].p2_coord);
                if (vecs[j].p1_set && !vecs[j].rej[0])
                    exp_q.push_back('{coord: vecs[j].p1_coord, owner: 1'b0});
                if (vecs[j].p2_set && !vecs[j].rej[1])
                    exp_q.push_back('{coord: vecs[j].p2_coord, owner: 1'b1});
            end else begin
                drive(1'b0, '0, 1'b0, '0);
            end
        end
        drain("table");

        // ---------------- contention ----------------
        @(negedge clk);
        drive(1'b1, 8'h10, 1'b1, 8'h11);
        exp_q.push_back('{coord: 8'h10, owner: 1'b0});
        exp_q.push_back('{coord: 8'h11, owner: 1'b1});
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.explode_valid) found = 1'b1;
        end
        check("cont_first_seen", found, 1);
        check("cont_first_coord", bus.explode_coord, 8'h10);
        check("cont_first_owner", bus.explode_owner, 0);
        @(negedge clk);
        check("cont_second_valid", bus.explode_valid, 1);
        check("cont_second_coord", bus.explode_coord, 8'h11);
        check("cont_second_owner", bus.explode_owner, 1);
        drain("cont");

        // ---------------- reset mid-fuse ----------------
        @(negedge clk);
        drive(1'b1, 8'h30, 1'b1, 8'h31);
        @(negedge clk);
        drive(1'b1, 8'h32, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        check("mid_num1_armed", bus.bomb_num_1, 2);
        check("mid_num2_armed", bus.bomb_num_2, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_bomb_num_1", bus.bomb_num_1, 0);
        check("mid_rst_bomb_num_2", bus.bomb_num_2, 0);
        check("mid_rst_explode_coord", bus.explode_coord, 0);
        check("mid_rst_explode_owner", bus.explode_owner, 0);
        check("mid_rst_explode_valid", bus.explode_valid, 0);
        check("mid_rst_place_reject", bus.place_reject, 0);
        snap = n_explode;
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        check("mid_no_explosions", n_explode - snap, 0);
        check("mid_num1_stays_zero", bus.bomb_num_1, 0);

        // ---------------- flame hit ----------------
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 8'h55);
        exp_q.push_back('{coord: 8'h55, owner: 1'b1});
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0);
        repeat (5) @(negedge clk);
        check("det_bomb_live", bus.bomb_num_2, 1);
        snap = n_explode;
        bus.detonate_valid = 1'b1;
        bus.detonate_coord = 8'h55;
`ifdef BOMB_TIMER_CHAIN_DETONATE_EN
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clk);
            bus.detonate_valid = 1'b0;
            if (bus.explode_valid) found = 1'b1;
        end
        check("chain_explode_within_2", found, 1);
        check("chain_coord", bus.explode_coord, 8'h55);
        check("chain_owner", bus.explode_owner, 1);
`else
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.detonate_valid = 1'b0;
        end
        check("nochain_no_early_explode", n_explode - snap, 0);
        check("nochain_bomb_still_live", bus.bomb_num_2, 1);
`endif
        drain("det");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
